huffman_stream_ctrl: RTL



---
 rtl/huffman_pkg.sv | 28 ++
 rtl/huffman_bitbuf.sv | 57 +++++
 rtl/huffman_stream_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared widths, controller state encoding and the legal code-length set
// used by the Huffman stream sequencer.
package huffman_pkg;

  localparam int unsigned WIN_W = 6;
  localparam int unsigned SYM_W = 4;
  localparam int unsigned LEN_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_ERR
  } ctrl_state_t;

  localparam logic [LEN_W-1:0] LEGAL_LENS [4] = '{4'd1, 4'd4, 4'd5, 4'd6};

  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (len == LEGAL_LENS[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/huffman_bitbuf.sv
// MSB-aligned bit buffer: appends input words below the valid bits and
// drops consumed code bits off the top, both in the same cycle if needed.
module huffman_bitbuf
  import huffman_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned BUF_W  = 32,
  localparam int unsigned CNT_W = $clog2(BUF_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              allow,
  input  logic              consume,
  input  logic [LEN_W-1:0]  cons_len,
  input  logic              flush,
  input  logic              clear_last,
  output logic              in_ready,
  output logic [WIN_W-1:0]  window,
  output logic [CNT_W-1:0]  cnt,
  output logic              last_seen
);

  localparam int unsigned ROOM = BUF_W - WORD_W;

  logic [BUF_W-1:0] bits;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] placed;
  logic [CNT_W-1:0] cons_bits;
  logic [CNT_W-1:0] base;
  logic             accept;

  assign in_ready  = allow && !last_seen && (cnt <= CNT_W'(ROOM));
  assign accept    = in_valid && in_ready;
  assign cons_bits = consume ? CNT_W'(cons_len) : '0;
  assign base      = cnt - cons_bits;
  assign shifted   = bits << cons_bits;
  // New word goes directly under whatever survives this cycle's consume.
  assign placed    = {in_data, {ROOM{1'b0}}} >> base;
  assign window    = bits[BUF_W-1 -: WIN_W];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      bits      <= '0;
      cnt       <= '0;
      last_seen <= 1'b0;
    end else begin
      bits <= accept ? (shifted | placed) : shifted;
      cnt  <= base + (accept ? CNT_W'(WORD_W) : '0);
      if (accept && in_last) last_seen <= 1'b1;
      else if (clear_last)   last_seen <= 1'b0;
    end
  end

endmodule

// File: rtl/huffman_stream_ctrl.sv
// Sequencer between a packed word stream and the Huffman decoder: issues one
// decode at a time, consumes the reported code length and emits symbols.
module huffman_stream_ctrl
  import huffman_pkg::*;
#(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned BUF_W   = 32,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WIN_W-1:0]  dec_window,
  output logic              dec_load,
  input  logic              dec_ready,
  input  logic [SYM_W-1:0]  dec_symbol,
  input  logic [LEN_W-1:0]  dec_len,
  output logic [SYM_W-1:0]  sym_data,
  output logic [LEN_W-1:0]  sym_len,
  output logic              sym_last,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              err_trunc,
  output logic              err_timeout,
  output logic [15:0]       sym_count
);

  localparam int unsigned CNT_W = $clog2(BUF_W + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  ctrl_state_t      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIN_W-1:0] window;
  logic [TMR_W-1:0] wait_cnt;
  logic             last_seen, allow, consume, flush, clear_last, len_fits, go;

  huffman_bitbuf #(
    .WORD_W(WORD_W),
    .BUF_W (BUF_W)
  ) u_bitbuf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .allow     (allow),
    .consume   (consume),
    .cons_len  (dec_len),
    .flush     (flush),
    .clear_last(clear_last),
    .in_ready  (in_ready),
    .window    (window),
    .cnt       (cnt),
    .last_seen (last_seen)
  );

  assign allow     = rst && (state != ST_ERR);
  assign len_fits  = CNT_W'(dec_len) <= cnt;
  assign go        = (cnt >= CNT_W'(WIN_W)) || (last_seen && (cnt != '0));
  assign dec_load  = (state == ST_ISSUE);
  assign sym_valid = (state == ST_OUT);

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    flush      = 1'b0;
    clear_last = 1'b0;
    case (state)
      ST_IDLE:  if (go) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (dec_ready) begin
          if (len_fits) begin
            consume    = 1'b1;
            state_next = ST_OUT;
          end else begin
            // Code overran the zero-padded tail: drop it and the stream.
            flush      = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (wait_cnt == TMR_W'(TIMEOUT - 1)) begin
          state_next = ST_ERR;
        end
      end
      ST_OUT: begin
        if (sym_ready) begin
          state_next = ST_IDLE;
          clear_last = sym_last;
        end
      end
      ST_ERR:   state_next = ST_ERR;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      dec_window  <= '0;
      sym_data    <= '0;
      sym_len     <= '0;
      sym_last    <= 1'b0;
      err_trunc   <= 1'b0;
      err_timeout <= 1'b0;
      sym_count   <= '0;
      wait_cnt    <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == ST_IDLE && go) dec_window <= window;
      if (consume) begin
        sym_data <= dec_symbol;
        sym_len  <= dec_len;
        sym_last <= last_seen && (CNT_W'(dec_len) == cnt);
      end
      if (flush) err_trunc <= 1'b1;
      if (state == ST_WAIT && state_next == ST_ERR) err_timeout <= 1'b1;
      if (state == ST_OUT && sym_ready) sym_count <= sym_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && state == ST_WAIT && dec_ready)
      assert (len_legal(dec_len)) else $error("illegal dec_len %0d", dec_len);
  end

endmodule
